// File: rtl/acs_path_metric.sv
// acs_path_metric: add-compare-select and path-metric registers for a 4-state hard-decision Viterbi decoder.
// Each enabled step produces new metrics, one survivor decision bit per state, and the best state index.
module acs_path_metric #(
    parameter int PM_W      = 6,
    parameter int INIT_BIAS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_acs,
    input  logic            i_start,
    input  logic [1:0]      HD1,
    input  logic [1:0]      HD2,
    input  logic [1:0]      HD3,
    input  logic [1:0]      HD4,
    input  logic [1:0]      HD5,
    input  logic [1:0]      HD6,
    input  logic [1:0]      HD7,
    input  logic [1:0]      HD8,
    output logic [PM_W-1:0] o_pm0,
    output logic [PM_W-1:0] o_pm1,
    output logic [PM_W-1:0] o_pm2,
    output logic [PM_W-1:0] o_pm3,
    output logic [3:0]      o_surv,
    output logic [1:0]      o_best,
    output logic            o_valid
);
    logic [1:0]      hd      [8];
    logic [PM_W-1:0] init_pm [4];
    logic [PM_W-1:0] old_pm  [4];
    logic [PM_W-1:0] sum_a   [4];
    logic [PM_W-1:0] sum_b   [4];
    logic [PM_W-1:0] raw_pm  [4];
    logic [PM_W-1:0] pm_d    [4];
    logic [PM_W-1:0] pm_q    [4];
    logic [3:0]      surv_d, surv_q;
    logic [1:0]      best_d, best_q;
    logic            valid_q;
    logic            norm;
    logic            b01, b23;
    logic [PM_W-1:0] m01, m23;

    assign hd = '{HD1, HD2, HD3, HD4, HD5, HD6, HD7, HD8};
    assign init_pm[0] = '0;
    assign init_pm[1] = PM_W'(INIT_BIAS);
    assign init_pm[2] = PM_W'(INIT_BIAS);
    assign init_pm[3] = PM_W'(INIT_BIAS);

    // Metric spread stays below half range, so all-MSB-set means clearing it is a uniform subtraction.
    assign norm = raw_pm[0][PM_W-1] & raw_pm[1][PM_W-1] & raw_pm[2][PM_W-1] & raw_pm[3][PM_W-1];

    genvar j;
    for (j = 0; j < 4; j++) begin : g_acs
        assign old_pm[j] = i_start ? init_pm[j] : pm_q[j];
        assign sum_a[j]  = old_pm[2*(j%2)]   + PM_W'(hd[2*j]);
        assign sum_b[j]  = old_pm[2*(j%2)+1] + PM_W'(hd[2*j+1]);
        assign surv_d[j] = sum_b[j] < sum_a[j];
        assign raw_pm[j] = surv_d[j] ? sum_b[j] : sum_a[j];
        assign pm_d[j]   = {raw_pm[j][PM_W-1] & ~norm, raw_pm[j][PM_W-2:0]};
    end

    // Strict comparisons keep the lower state index on ties.
    always_comb begin
        b01    = pm_d[1] < pm_d[0];
        b23    = pm_d[3] < pm_d[2];
        m01    = b01 ? pm_d[1] : pm_d[0];
        m23    = b23 ? pm_d[3] : pm_d[2];
        best_d = (m23 < m01) ? {1'b1, b23} : {1'b0, b01};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pm_q    <= init_pm;
            surv_q  <= '0;
            best_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= en_acs;
            if (en_acs) begin
                pm_q   <= pm_d;
                surv_q <= surv_d;
                best_q <= best_d;
            end else if (i_start) begin
                pm_q   <= init_pm;
                surv_q <= '0;
                best_q <= '0;
            end
        end
    end

    assign o_pm0   = pm_q[0];
    assign o_pm1   = pm_q[1];
    assign o_pm2   = pm_q[2];
    assign o_pm3   = pm_q[3];
    assign o_surv  = surv_q;
    assign o_best  = best_q;
    assign o_valid = valid_q;
endmodule

// File: tb/tb_acs_path_metric.sv
// tb_acs_path_metric: directed vectors with hand-computed metrics for the 4-state ACS stage.
module tb_acs_path_metric;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_acs = 1'b0;
    logic       i_start = 1'b0;
    logic [1:0] HD1 = '0, HD2 = '0, HD3 = '0, HD4 = '0, HD5 = '0, HD6 = '0, HD7 = '0, HD8 = '0;
    logic [5:0] o_pm0, o_pm1, o_pm2, o_pm3;
    logic [3:0] o_surv;
    logic [1:0] o_best;
    logic       o_valid;
    int         vecs = 0;
    int         errs = 0;

    acs_path_metric #(.PM_W(6), .INIT_BIAS(4)) dut (
        .clk(clk), .rst(rst), .en_acs(en_acs), .i_start(i_start),
        .HD1(HD1), .HD2(HD2), .HD3(HD3), .HD4(HD4),
        .HD5(HD5), .HD6(HD6), .HD7(HD7), .HD8(HD8),
        .o_pm0(o_pm0), .o_pm1(o_pm1), .o_pm2(o_pm2), .o_pm3(o_pm3),
        .o_surv(o_surv), .o_best(o_best), .o_valid(o_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected metrics given as {pm0,pm1,pm2,pm3} in 6-bit fields.
    task automatic chk_all(input string tag, input logic [23:0] pm, input logic [3:0] surv,
                           input logic [1:0] best, input logic valid);
        chk({tag, " pm"}, {8'd0, o_pm0, o_pm1, o_pm2, o_pm3}, {8'd0, pm});
        chk({tag, " surv"}, {28'd0, o_surv}, {28'd0, surv});
        chk({tag, " best"}, {30'd0, o_best}, {30'd0, best});
        chk({tag, " valid"}, {31'd0, o_valid}, {31'd0, valid});
    endtask

    // hv packs HD1 in [15:14] down to HD8 in [1:0].
    task automatic step(input logic [15:0] hv, input logic st);
        {HD1, HD2, HD3, HD4, HD5, HD6, HD7, HD8} = hv;
        en_acs = 1'b1;
        i_start = st;
        @(posedge clk); #1;
        en_acs = 1'b0;
        i_start = 1'b0;
        {HD1, HD2, HD3, HD4, HD5, HD6, HD7, HD8} = 16'hFFFF;
    endtask

    task automatic idle;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [5:0] e;
        @(posedge clk); #1;
        do_reset();
        chk_all("reset", {6'd0, 6'd4, 6'd4, 6'd4}, 4'b0000, 2'd0, 1'b0);

        // Rx=00 twice
        step({2'd0, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1}, 1'b0);
        chk_all("rx00_1", {6'd0, 6'd5, 6'd2, 6'd5}, 4'b0000, 2'd0, 1'b1);
        step({2'd0, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1}, 1'b0);
        chk_all("rx00_2", {6'd0, 6'd3, 6'd2, 6'd3}, 4'b0000, 2'd0, 1'b1);

        // All-2 metrics: climb to 30, then normalise on step 16
        do_reset();
        for (int s = 1; s <= 16; s++) begin
            step(16'hAAAA, 1'b0);
            e = (s == 16) ? 6'd0 : 6'(2 * s);
            if (s == 1) chk_all("all2_s1", {6'd2, 6'd6, 6'd2, 6'd6}, 4'b0000, 2'd0, 1'b1);
            else chk({"all2 pm s", $sformatf("%0d", s)}, {8'd0, o_pm0, o_pm1, o_pm2, o_pm3}, {8'd0, e, e, e, e});
        end
        chk_all("all2_norm", 24'd0, 4'b0000, 2'd0, 1'b1);

        // Select with HD=3 on state 0, strict win on state 1, tie on state 3
        step({2'd3, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 1'b1);
        chk_all("select", {6'd3, 6'd4, 6'd0, 6'd4}, 4'b0010, 2'd2, 1'b1);
        step({2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0}, 1'b0);
        chk_all("tie", {6'd4, 6'd0, 6'd3, 6'd0}, 4'b0000, 2'd1, 1'b1);

        // Pulses separated by idle gaps
        step(16'h0000, 1'b0);
        chk_all("gap_s1", 24'd0, 4'b1111, 2'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            idle();
            chk_all("gap_hold1", 24'd0, 4'b1111, 2'd0, 1'b0);
        end
        step({2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0}, 1'b0);
        chk_all("gap_s2", {6'd1, 6'd0, 6'd2, 6'd0}, 4'b1000, 2'd1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            idle();
            chk_all("gap_hold2", {6'd1, 6'd0, 6'd2, 6'd0}, 4'b1000, 2'd1, 1'b0);
        end

        // Frame start with Rx=11 mid-stream
        step({2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 2'd1}, 1'b1);
        chk_all("start_rx11", {6'd2, 6'd5, 6'd0, 6'd5}, 4'b0000, 2'd2, 1'b1);

        // Start without en reloads the init vector
        step(16'h0000, 1'b0);
        i_start = 1'b1;
        idle();
        i_start = 1'b0;
        chk_all("start_only", {6'd0, 6'd4, 6'd4, 6'd4}, 4'b0000, 2'd0, 1'b0);

        // Reset during back-to-back steps
        {HD1, HD2, HD3, HD4, HD5, HD6, HD7, HD8} = 16'h5555;
        en_acs = 1'b1;
        idle();
        chk_all("b2b", {6'd1, 6'd5, 6'd1, 6'd5}, 4'b0000, 2'd0, 1'b1);
        idle();
        chk({"b2b2 valid"}, {31'd0, o_valid}, 32'd1);
        rst = 1'b1;
        i_start = 1'b1;
        idle();
        rst = 1'b0;
        en_acs = 1'b0;
        i_start = 1'b0;
        chk_all("rst_mid", {6'd0, 6'd4, 6'd4, 6'd4}, 4'b0000, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
